// File: rtl/benes_route_sched_pkg.sv
// rtl/benes_route_sched_pkg.sv - shared constants, types and select unpacking for the Benes route sequencer
package benes_route_sched_pkg;
  localparam int STAGE_NUM  = 5;
  localparam int SWITCH_NUM = 16;
  localparam int CFG_DEPTH  = 16;
  localparam int CFG_AW     = 4;
  localparam int LEN_W      = 8;
  localparam int NET_LAT    = 7;
  localparam int SEL_W      = STAGE_NUM * SWITCH_NUM;

  typedef logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] stage_sel_t;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STREAM, DRAIN} route_state_e;

  // Table words are stage-major; the select outputs are switch-major.
  function automatic stage_sel_t to_stage_sel(input logic [SEL_W-1:0] flat);
    stage_sel_t s;
    for (int st = 0; st < STAGE_NUM; st++) begin
      for (int sw = 0; sw < SWITCH_NUM; sw++) begin
        s[sw][st] = flat[st*SWITCH_NUM + sw];
      end
    end
    return s;
  endfunction
endpackage

// File: rtl/benes_route_sched_if.sv
// rtl/benes_route_sched_if.sv - per-direction transfer request handshake
interface benes_route_sched_if;
  import benes_route_sched_pkg::*;

  logic              valid;
  logic              ready;
  logic [CFG_AW-1:0] cfg;
  logic [LEN_W-1:0]  len;

  modport master (output valid, output cfg, output len, input ready);
  modport slave  (input valid, input cfg, input len, output ready);
endinterface

// File: rtl/benes_route_sched_dir_seq.sv
// rtl/benes_route_sched_dir_seq.sv - one direction's request FSM, beat/drain counters and dst_valid delay line
module benes_route_sched_dir_seq
  import benes_route_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  benes_route_sched_if.slave req,
  output logic              rd_req,
  output logic [CFG_AW-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic [SEL_W-1:0]  rd_data,
  output stage_sel_t        sel,
  output logic              src_en,
  output logic              dst_valid,
  output logic              done,
  output logic              busy
);
  localparam int DRAIN_W = $clog2(NET_LAT);

  route_state_e       state;
  logic               ready_q;
  logic [CFG_AW-1:0]  cfg_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [NET_LAT-1:0] dly;

  assign req.ready = ready_q;
  assign rd_req    = (state == FETCH);
  assign rd_addr   = cfg_q;
  assign dst_valid = dly[NET_LAT-1];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      cfg_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      sel       <= '0;
      src_en    <= 1'b0;
      done      <= 1'b0;
      dly       <= '0;
    end else begin
      done <= 1'b0;
      dly  <= {dly[NET_LAT-2:0], src_en};
      case (state)
        IDLE: begin
          if (req.valid && ready_q) begin
            cfg_q   <= req.cfg;
            ready_q <= 1'b0;
            // Zero-length requests complete without touching the table or selects.
            if (req.len == '0) begin
              done <= 1'b1;
            end else begin
              beat_cnt <= req.len;
              state    <= FETCH;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        FETCH: begin
          if (rd_gnt) state <= LOAD;
        end
        LOAD: begin
          sel    <= to_stage_sel(rd_data);
          src_en <= 1'b1;
          state  <= STREAM;
        end
        STREAM: begin
          if (beat_cnt == LEN_W'(1)) begin
            src_en    <= 1'b0;
            drain_cnt <= DRAIN_W'(NET_LAT - 1);
            state     <= DRAIN;
          end else begin
            beat_cnt <= beat_cnt - LEN_W'(1);
          end
        end
        DRAIN: begin
          // done lines up with the final dst_valid beat leaving the delay line.
          if (drain_cnt == '0) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
            if (drain_cnt == DRAIN_W'(1)) done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/benes_route_sched.sv
// rtl/benes_route_sched.sv - Benes R2M/M2R route sequencer: shared config table, read-port arbiter, two direction FSMs
module benes_route_sched
  import benes_route_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [CFG_AW-1:0] cfg_wr_addr,
  input  logic [SEL_W-1:0]  cfg_wr_data,
  benes_route_sched_if.slave r2m_req,
  benes_route_sched_if.slave m2r_req,
  output stage_sel_t        o_module_select,
  output stage_sel_t        o_slot_select,
  output logic              r2m_src_en,
  output logic              m2r_src_en,
  output logic              r2m_dst_valid,
  output logic              m2r_dst_valid,
  output logic              r2m_done,
  output logic              m2r_done,
  output logic              o_busy
);
  logic [SEL_W-1:0]  cfg_mem [CFG_DEPTH];
  logic [SEL_W-1:0]  rd_data;
  logic              r2m_rd_req, m2r_rd_req;
  logic              r2m_gnt, m2r_gnt;
  logic [CFG_AW-1:0] r2m_rd_addr, m2r_rd_addr;
  logic              r2m_busy, m2r_busy;
  logic              prio_r2m;

  // The pointer only moves on contention, so the last contention winner yields next time.
  assign r2m_gnt = r2m_rd_req && (!m2r_rd_req || prio_r2m);
  assign m2r_gnt = m2r_rd_req && !r2m_gnt;
  assign o_busy  = r2m_busy | m2r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r2m <= 1'b1;
    end else if (r2m_rd_req && m2r_rd_req) begin
      prio_r2m <= !prio_r2m;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en) cfg_mem[cfg_wr_addr] <= cfg_wr_data;
    if (r2m_gnt || m2r_gnt) rd_data <= cfg_mem[r2m_gnt ? r2m_rd_addr : m2r_rd_addr];
  end

  benes_route_sched_dir_seq u_r2m (
    .clk       (clk),
    .rst       (rst),
    .req       (r2m_req),
    .rd_req    (r2m_rd_req),
    .rd_addr   (r2m_rd_addr),
    .rd_gnt    (r2m_gnt),
    .rd_data   (rd_data),
    .sel       (o_module_select),
    .src_en    (r2m_src_en),
    .dst_valid (r2m_dst_valid),
    .done      (r2m_done),
    .busy      (r2m_busy)
  );

  benes_route_sched_dir_seq u_m2r (
    .clk       (clk),
    .rst       (rst),
    .req       (m2r_req),
    .rd_req    (m2r_rd_req),
    .rd_addr   (m2r_rd_addr),
    .rd_gnt    (m2r_gnt),
    .rd_data   (rd_data),
    .sel       (o_slot_select),
    .src_en    (m2r_src_en),
    .dst_valid (m2r_dst_valid),
    .done      (m2r_done),
    .busy      (m2r_busy)
  );
endmodule

// File: tb/tb_benes_route_sched.sv
// tb/tb_benes_route_sched.sv - scoreboard bench for benes_route_sched
module tb_benes_route_sched;
  import benes_route_sched_pkg::*;

  localparam int LAT = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_wr_en = 1'b0;
  logic [CFG_AW-1:0] cfg_wr_addr = '0;
  logic [SEL_W-1:0]  cfg_wr_data = '0;
  stage_sel_t        o_module_select, o_slot_select;
  logic              r2m_src_en, m2r_src_en, r2m_dst_valid, m2r_dst_valid;
  logic              r2m_done, m2r_done, o_busy;

  benes_route_sched_if r2m_if ();
  benes_route_sched_if m2r_if ();

  benes_route_sched dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_data     (cfg_wr_data),
    .r2m_req         (r2m_if),
    .m2r_req         (m2r_if),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .r2m_src_en      (r2m_src_en),
    .m2r_src_en      (m2r_src_en),
    .r2m_dst_valid   (r2m_dst_valid),
    .m2r_dst_valid   (m2r_dst_valid),
    .r2m_done        (r2m_done),
    .m2r_done        (m2r_done),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_cyc;
    int         first_src;
    int         len;
    stage_sel_t sel;
  } exp_t;

  exp_t             expq [2][$];
  int               src_cnt [2];
  int               dst_cnt [2];
  int               first_src [2];
  int               last_dst [2];
  int               free_at [2];
  stage_sel_t       sel_last [2];
  bit               rr_r2m;
  logic [SEL_W-1:0] mem_m [CFG_DEPTH];
  int               n_pass = 0;
  int               n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_sel(input string name, input stage_sel_t act, input stage_sel_t exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Selects addressed as [switch][stage]; table bit i is stage i/SWITCH_NUM, switch i%SWITCH_NUM.
  function automatic stage_sel_t model_sel(input logic [SEL_W-1:0] v);
    stage_sel_t s;
    for (int i = 0; i < SEL_W; i++) s[i % SWITCH_NUM][i / SWITCH_NUM] = v[i];
    return s;
  endfunction

  function automatic logic [SEL_W-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[SEL_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_dir(input int d, input logic src, input logic dst, input logic dn, input stage_sel_t sel);
    exp_t e;
    if (src) begin
      if (expq[d].size() == 0) begin
        chk(d == 0 ? "r2m_src_unexpected" : "m2r_src_unexpected", 1, 0);
      end else begin
        if (src_cnt[d] == 0) first_src[d] = cyc;
        src_cnt[d]++;
        chk_sel(d == 0 ? "r2m_sel_stream" : "m2r_sel_stream", sel, expq[d][0].sel);
      end
    end
    if (dst) begin
      dst_cnt[d]++;
      last_dst[d] = cyc;
    end
    if (dn) begin
      if (expq[d].size() == 0) begin
        chk(d == 0 ? "r2m_done_unexpected" : "m2r_done_unexpected", 1, 0);
      end else begin
        e = expq[d].pop_front();
        chk(d == 0 ? "r2m_done_cycle" : "m2r_done_cycle", cyc, e.done_cyc);
        chk(d == 0 ? "r2m_src_beats" : "m2r_src_beats", src_cnt[d], e.len);
        chk(d == 0 ? "r2m_dst_beats" : "m2r_dst_beats", dst_cnt[d], e.len);
        chk_sel(d == 0 ? "r2m_sel_done" : "m2r_sel_done", sel, e.sel);
        if (e.len > 0) begin
          chk(d == 0 ? "r2m_first_src" : "m2r_first_src", first_src[d], e.first_src);
          chk(d == 0 ? "r2m_last_dst" : "m2r_last_dst", last_dst[d], cyc);
        end
      end
      src_cnt[d] = 0;
      dst_cnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_dir(0, r2m_src_en, r2m_dst_valid, r2m_done, o_module_select);
      mon_dir(1, m2r_src_en, m2r_dst_valid, m2r_done, o_slot_select);
    end
  end

  // Called one step after a rising edge; the requests are accepted at the next edge.
  task automatic issue_pair(input bit en0, input bit en1,
                            input logic [CFG_AW-1:0] c0, input logic [CFG_AW-1:0] c1,
                            input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1);
    int a, g, loser;
    bit en [2];
    logic [CFG_AW-1:0] c [2];
    logic [LEN_W-1:0]  l [2];
    bit cont;
    exp_t e;
    a = cyc;
    en[0] = en0; en[1] = en1;
    c[0] = c0;   c[1] = c1;
    l[0] = l0;   l[1] = l1;
    cont  = en0 && en1 && (l0 != 0) && (l1 != 0);
    loser = rr_r2m ? 1 : 0;
    for (int d = 0; d < 2; d++) begin
      if (en[d]) begin
        chk(d == 0 ? "r2m_ready_at_issue" : "m2r_ready_at_issue",
            int'(d == 0 ? r2m_if.ready : m2r_if.ready), 1);
        e.len = int'(l[d]);
        if (l[d] == 0) begin
          e.done_cyc  = a + 1;
          e.first_src = 0;
          e.sel       = sel_last[d];
        end else begin
          g = a + 1 + ((cont && d == loser) ? 1 : 0);
          e.first_src = g + 2;
          e.done_cyc  = g + 1 + e.len + LAT;
          sel_last[d] = model_sel(mem_m[c[d]]);
          e.sel       = sel_last[d];
        end
        free_at[d] = e.done_cyc + 1;
        expq[d].push_back(e);
      end
    end
    if (cont) rr_r2m = !rr_r2m;
    r2m_if.valid = en0; r2m_if.cfg = c0; r2m_if.len = l0;
    m2r_if.valid = en1; m2r_if.cfg = c1; m2r_if.len = l1;
    step();
    r2m_if.valid = 1'b0;
    m2r_if.valid = 1'b0;
  endtask

  task automatic wait_both();
    int guard;
    guard = 0;
    while ((cyc < free_at[0] || cyc < free_at[1]) && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_src"}, int'({r2m_src_en, m2r_src_en}), 0);
    chk({tag, "_dst"}, int'({r2m_dst_valid, m2r_dst_valid}), 0);
    chk({tag, "_done"}, int'({r2m_done, m2r_done}), 0);
    chk_sel({tag, "_module_sel"}, o_module_select, '0);
    chk_sel({tag, "_slot_sel"}, o_slot_select, '0);
  endtask

  task automatic flush_model();
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      src_cnt[d]  = 0;
      dst_cnt[d]  = 0;
      sel_last[d] = '0;
      free_at[d]  = cyc;
    end
    rr_r2m = 1'b1;
  endtask

  initial begin
    int a, guard;
    int issued [2];
    bit e0, e1;
    logic [SEL_W-1:0] w;

    r2m_if.valid = 1'b0; r2m_if.cfg = '0; r2m_if.len = '0;
    m2r_if.valid = 1'b0; m2r_if.cfg = '0; m2r_if.len = '0;
    flush_model();

    rst = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    chk("reset_r2m_ready", int'(r2m_if.ready), 0);
    chk("reset_m2r_ready", int'(m2r_if.ready), 0);
    rst = 1'b0;
    step();
    chk("post_reset_r2m_ready", int'(r2m_if.ready), 1);
    chk("post_reset_m2r_ready", int'(m2r_if.ready), 1);

    for (int i = 0; i < CFG_DEPTH; i++) begin
      w = rand_word();
      cfg_wr_en = 1'b1; cfg_wr_addr = CFG_AW'(i); cfg_wr_data = w;
      mem_m[i] = w;
      step();
    end
    cfg_wr_en = 1'b0;
    free_at[0] = cyc; free_at[1] = cyc;

    // Single R2M burst with explicit timing points.
    a = cyc;
    issue_pair(1'b1, 1'b0, 4'd3, 4'd0, 8'd4, 8'd0);
    while (cyc < a + 5) step();
    chk("t1_busy", int'(o_busy), 1);
    while (cyc < a + 13) step();
    chk("t1_done_at_13", int'(r2m_done), 1);
    chk("t1_ready_low_at_13", int'(r2m_if.ready), 0);
    step();
    chk("t1_ready_at_14", int'(r2m_if.ready), 1);
    wait_both();

    // Simultaneous pairs: R2M wins first, M2R wins the next contention.
    issue_pair(1'b1, 1'b1, 4'd1, 4'd2, 8'd5, 8'd3);
    wait_both();
    issue_pair(1'b1, 1'b1, 4'd4, 4'd6, 8'd3, 8'd5);
    wait_both();

    issue_pair(1'b1, 1'b0, 4'd7, 4'd0, 8'd0, 8'd0);
    wait_both();
    issue_pair(1'b0, 1'b1, 4'd0, 4'd8, 8'd0, 8'd0);
    wait_both();

    // Write to index 5 during the FETCH that reads it: old data is loaded.
    issue_pair(1'b1, 1'b0, 4'd5, 4'd0, 8'd3, 8'd0);
    w = ~mem_m[5];
    cfg_wr_en = 1'b1; cfg_wr_addr = 4'd5; cfg_wr_data = w;
    step();
    cfg_wr_en = 1'b0;
    mem_m[5] = w;
    wait_both();
    issue_pair(1'b1, 1'b0, 4'd5, 4'd0, 8'd2, 8'd0);
    wait_both();

    // Reset during the second beat of an 8-beat burst.
    issue_pair(1'b1, 1'b0, 4'd9, 4'd0, 8'd8, 8'd0);
    step(); step(); step();
    chk("t6_beat2_src", int'(r2m_src_en), 1);
    rst = 1'b1;
    step();
    chk_all_zero("abort");
    flush_model();
    rst = 1'b0;
    step();
    chk("abort_r2m_ready", int'(r2m_if.ready), 1);
    chk("abort_m2r_ready", int'(m2r_if.ready), 1);
    free_at[0] = cyc; free_at[1] = cyc;
    issue_pair(1'b1, 1'b0, 4'd9, 4'd0, 8'd3, 8'd0);
    wait_both();

    issued[0] = 0; issued[1] = 0;
    for (int t = 0; t < 4000 && (issued[0] < 40 || issued[1] < 40); t++) begin
      e0 = (cyc >= free_at[0]) && (issued[0] < 40) && ($urandom_range(0, 2) != 0);
      e1 = (cyc >= free_at[1]) && (issued[1] < 40) && ($urandom_range(0, 2) != 0);
      if (e0 || e1) begin
        issued[0] += int'(e0);
        issued[1] += int'(e1);
        issue_pair(e0, e1, CFG_AW'($urandom_range(0, 15)), CFG_AW'($urandom_range(0, 15)),
                   LEN_W'($urandom_range(0, 10)), LEN_W'($urandom_range(0, 10)));
      end else begin
        step();
      end
    end

    guard = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && guard < 300) begin
      step();
      guard++;
    end
    chk("scoreboard_drained", expq[0].size() + expq[1].size(), 0);
    step();
    chk("final_busy", int'(o_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
